sha_msg_padder: RTL and testbench

SHA_MSG_PADDER -- requirements
Module: sha_msg_padder

---
 rtl/sha_msg_padder.sv | 172 +++++++++++++++++
 tb/tb_sha_msg_padder.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_msg_padder.sv
// sha_msg_padder: SHA-256 message padder, byte stream in, 512-bit blocks out.
// Define SHA_MSG_SCHED_EN to add the W[16..63] schedule expansion stage.
module sha_msg_padder (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [0:15][31:0] blk_W,
  output logic              blk_first,
  output logic              blk_last
`ifdef SHA_MSG_SCHED_EN
  ,
  output logic [0:63][31:0] blk_W64
`endif
);

`ifdef SHA_MSG_SCHED_EN
  typedef enum logic [1:0] {FILL, PAD, EXPAND, EMIT} state_t;
  localparam state_t FORMED = EXPAND;
`else
  typedef enum logic [1:0] {FILL, PAD, EMIT} state_t;
  localparam state_t FORMED = EMIT;
`endif

  state_t            state;
  state_t            state_nxt;
  logic [5:0]        ptr;
  logic [6:0]        p_cnt;
  logic [63:0]       bit_cnt;
  logic [0:15][31:0] blk_q;
  logic              first_pend;
  logic              last_q;
  logic              extra_pend;
  logic              extra_80;
  logic              byte_acc;
  logic              blk_acc;

  assign byte_acc = in_valid && (state == FILL);
  assign blk_acc  = blk_ready && (state == EMIT);

`ifdef SHA_MSG_SCHED_EN
  logic [5:0]         t_idx;
  logic [16:63][31:0] w_ext;
  logic [0:63][31:0]  w_all;
  logic [31:0]        w_new;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign w_all = {blk_q, w_ext};
  assign w_new = sig1(w_all[t_idx - 6'd2])
               + w_all[t_idx - 6'd7]
               + sig0(w_all[t_idx - 6'd15])
               + w_all[t_idx - 6'd16];

  // schedule expansion: one new word per EXPAND cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      t_idx <= 6'd16;
      w_ext <= '0;
    end else if (state == EXPAND) begin
      w_ext[t_idx] <= w_new;
      t_idx <= (t_idx == 6'd63) ? 6'd16 : t_idx + 6'd1;
    end
  end
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= FILL;
    else       state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL:
        if (byte_acc) begin
          if (in_last)              state_nxt = PAD;
          else if (ptr == 6'd63)    state_nxt = FORMED;
        end
      PAD: state_nxt = FORMED;
`ifdef SHA_MSG_SCHED_EN
      EXPAND:
        if (t_idx == 6'd63) state_nxt = EMIT;
`endif
      EMIT:
        if (blk_acc) state_nxt = extra_pend ? PAD : FILL;
      default: state_nxt = FILL;
    endcase
  end

  // block buffer, byte pointer, bit counter and message flags;
  // buffer is zeroed on each transfer so padding only writes non-zero bytes
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr        <= '0;
      p_cnt      <= '0;
      bit_cnt    <= '0;
      blk_q      <= '0;
      first_pend <= 1'b1;
      last_q     <= 1'b0;
      extra_pend <= 1'b0;
      extra_80   <= 1'b0;
    end else begin
      unique case (state)
        FILL:
          if (byte_acc) begin
            blk_q[ptr[5:2]][{~ptr[1:0], 3'b000} +: 8] <= in_data;
            bit_cnt <= bit_cnt + 64'd8;
            ptr     <= ptr + 6'd1;
            if (in_last)           p_cnt  <= {1'b0, ptr} + 7'd1;
            else if (ptr == 6'd63) last_q <= 1'b0;
          end
        PAD:
          if (extra_pend) begin
            blk_q[0][31:24] <= extra_80 ? 8'h80 : 8'h00;
            blk_q[14]       <= bit_cnt[63:32];
            blk_q[15]       <= bit_cnt[31:0];
            extra_pend      <= 1'b0;
            last_q          <= 1'b1;
          end else if (p_cnt == 7'd64) begin
            extra_pend <= 1'b1;
            extra_80   <= 1'b1;
            last_q     <= 1'b0;
          end else begin
            blk_q[p_cnt[5:2]][{~p_cnt[1:0], 3'b000} +: 8] <= 8'h80;
            if (p_cnt <= 7'd55) begin
              blk_q[14] <= bit_cnt[63:32];
              blk_q[15] <= bit_cnt[31:0];
              last_q    <= 1'b1;
            end else begin
              extra_pend <= 1'b1;
              extra_80   <= 1'b0;
              last_q     <= 1'b0;
            end
          end
        EMIT:
          if (blk_acc) begin
            blk_q      <= '0;
            ptr        <= '0;
            first_pend <= last_q;
            if (last_q) bit_cnt <= '0;
          end
        default: ;
      endcase
    end
  end

  // outputs decoded from state and held registers
  always_comb begin
    in_ready  = (state == FILL);
    blk_valid = (state == EMIT);
    blk_first = (state == EMIT) && first_pend;
    blk_last  = (state == EMIT) && last_q;
    blk_W     = blk_q;
`ifdef SHA_MSG_SCHED_EN
    blk_W64   = w_all;
`endif
  end

endmodule

// File: tb/tb_sha_msg_padder.sv
// tb_sha_msg_padder: randomized bench for sha_msg_padder against a
// byte-level SHA-256 padding reference model.
module tb_sha_msg_padder;
  typedef logic [0:15][31:0] blk_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic       blk_valid;
  logic       blk_ready = 1'b0;
  blk_t       blk_W;
  logic       blk_first;
  logic       blk_last;
`ifdef SHA_MSG_SCHED_EN
  logic [0:63][31:0] blk_W64;
  localparam int SCHED = 48;
`else
  localparam int SCHED = 0;
`endif

  int total = 0;
  int bad = 0;
  logic [7:0] mq[$];
  blk_t got_blk[$];

  always #5 clk = ~clk;

  sha_msg_padder dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_last(in_last),
    .in_ready(in_ready),
    .blk_valid(blk_valid),
    .blk_ready(blk_ready),
    .blk_W(blk_W),
    .blk_first(blk_first),
    .blk_last(blk_last)
`ifdef SHA_MSG_SCHED_EN
    ,
    .blk_W64(blk_W64)
`endif
  );

`ifdef SHA_MSG_SCHED_EN
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [0:63][31:0] expand(input blk_t b);
    logic [31:0] w[64];
    logic [0:63][31:0] r;
    logic [31:0] s0, s1;
    for (int i = 0; i < 16; i++) w[i] = b[i];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int i = 0; i < 64; i++) r[i] = w[i];
    return r;
  endfunction
`endif

  function automatic void fill_rep(input logic [7:0] v, input int n);
    mq.delete();
    for (int i = 0; i < n; i++) mq.push_back(v);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; blk_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Sends mq with random valid/ready duty and checks every block.
  task automatic run_msg(input int vp, input int rp);
    logic [7:0] pad[$];
    blk_t expb[$];
    blk_t w, hold;
    logic [63:0] bits;
    int bi, nb, got, cyc;
    logic holding;
    pad = mq;
    bits = 64'(mq.size()) << 3;
    pad.push_back(8'h80);
    while (pad.size() % 64 != 56) pad.push_back(8'h00);
    for (int i = 7; i >= 0; i--) pad.push_back(bits[8*i +: 8]);
    nb = pad.size() / 64;
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < 64; i++) w[i/4][8*(3-i%4) +: 8] = pad[64*b + i];
      expb.push_back(w);
    end
    got_blk.delete();
    bi = 0; got = 0; cyc = 0; holding = 1'b0;
    while (got < nb && cyc < 5000) begin
      @(negedge clk);
      in_valid = (bi < mq.size()) && ($urandom_range(99) < vp);
      if (in_valid) begin
        in_data = mq[bi];
        in_last = (bi == mq.size() - 1);
      end else begin
        in_data = 8'($urandom);
        in_last = 1'($urandom);
      end
      blk_ready = ($urandom_range(99) < rp);
      #1;
      if (holding) begin
        total++;
        if (blk_valid !== 1'b1 || blk_W !== hold) begin
          bad++;
          $display("FAIL hold_stable: valid=%b W=%h required W=%h", blk_valid, blk_W, hold);
        end
      end
      if (blk_valid) begin
        total++;
        if (in_ready !== 1'b0) begin
          bad++;
          $display("FAIL ready_in_emit: in_ready=%b required 0", in_ready);
        end
      end
      if (in_valid && in_ready) bi++;
      if (blk_valid && blk_ready) begin
        total++;
        if (blk_W !== expb[got] || blk_first !== (got == 0) || blk_last !== (got == nb - 1)) begin
          bad++;
          $display("FAIL block%0d len=%0d: W=%h f=%b l=%b required W=%h f=%b l=%b",
                   got, mq.size(), blk_W, blk_first, blk_last, expb[got], got == 0, got == nb - 1);
        end
`ifdef SHA_MSG_SCHED_EN
        total++;
        if (blk_W64 !== expand(expb[got])) begin
          bad++;
          $display("FAIL w64 block%0d: W16=%h required %h", got, blk_W64[16], expand(expb[got]) [16]);
        end
`endif
        got_blk.push_back(blk_W);
        got++;
        holding = 1'b0;
      end else if (blk_valid) begin
        holding = 1'b1;
        hold = blk_W;
      end
      cyc++;
    end
    total++;
    if (got != nb) begin
      bad++;
      $display("FAIL timeout len=%0d: blocks=%0d required %0d", mq.size(), got, nb);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; blk_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if (in_ready !== 1'b1 || blk_valid !== 1'b0 || blk_first !== 1'b0 ||
        blk_last !== 1'b0 || blk_W !== '0) begin
      bad++;
      $display("FAIL reset: rdy=%b v=%b f=%b l=%b W=%h required 1 0 0 0 0",
               in_ready, blk_valid, blk_first, blk_last, blk_W);
    end
  endtask

  task automatic test_known();
    mq.delete();
    mq.push_back(8'h87); mq.push_back(8'h02); mq.push_back(8'h79);
    run_msg(100, 100);
    total++;
    if (got_blk.size() != 1 || got_blk[0][0] !== 32'h87027980 || got_blk[0][15] !== 32'h18) begin
      bad++;
      $display("FAIL abc_words: n=%0d W0/W15 wrong", got_blk.size());
    end
    fill_rep(8'h61, 55);
    run_msg(100, 100);
    total++;
    if (got_blk.size() != 1 || got_blk[0][13] !== 32'h61616180 || got_blk[0][15] !== 32'h1B8) begin
      bad++;
      $display("FAIL len55: n=%0d W13/W15 wrong", got_blk.size());
    end
    fill_rep(8'h61, 56);
    run_msg(100, 100);
    total++;
    if (got_blk.size() != 2 || got_blk[0][14] !== 32'h80000000 || got_blk[0][15] !== 32'h0 ||
        got_blk[1][0] !== 32'h0 || got_blk[1][15] !== 32'h1C0) begin
      bad++;
      $display("FAIL len56: n=%0d words wrong", got_blk.size());
    end
    fill_rep(8'h61, 64);
    run_msg(100, 100);
    total++;
    if (got_blk.size() != 2 || got_blk[0][7] !== 32'h61616161 || got_blk[0][15] !== 32'h61616161 ||
        got_blk[1][0] !== 32'h80000000 || got_blk[1][15] !== 32'h200) begin
      bad++;
      $display("FAIL len64: n=%0d words wrong", got_blk.size());
    end
  endtask

  task automatic test_latency();
    int n, len, lat;
    for (int c = 0; c < 2; c++) begin
      do_reset();
      len = (c == 0) ? 3 : 64;
      lat = ((c == 0) ? 2 : 1) + SCHED;
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'(i); in_last = (c == 0) && (i == len - 1);
      end
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      n = 1;
      #1;
      while (!blk_valid && n < 200) begin
        @(negedge clk);
        #1;
        n++;
      end
      total++;
      if (n != lat) begin
        bad++;
        $display("FAIL latency case%0d: cycles=%0d required %0d", c, n, lat);
      end
    end
    do_reset();
  endtask

  task automatic test_backpressure();
    blk_t hold;
    int n;
    do_reset();
    mq.delete();
    mq.push_back(8'h87); mq.push_back(8'h02); mq.push_back(8'h79);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = mq[i]; in_last = (i == 2);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    n = 0;
    #1;
    while (!blk_valid && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    hold = blk_W;
    total++;
    if (blk_valid !== 1'b1 || hold[0] !== 32'h87027980) begin
      bad++;
      $display("FAIL bp_first: valid=%b W0=%h required 1 87027980", blk_valid, hold[0]);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = 1'($urandom);
      #1;
      total++;
      if (blk_valid !== 1'b1 || blk_W !== hold || in_ready !== 1'b0 || blk_last !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold%0d: v=%b rdy=%b l=%b W0=%h required 1 0 1 %h",
                 k, blk_valid, in_ready, blk_last, blk_W[0], hold[0]);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    #1;
    total++;
    if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: v=%b rdy=%b required 0 1", blk_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'($urandom); in_last = 1'b0;
    end
    do_reset();
    mq.delete();
    mq.push_back(8'h87); mq.push_back(8'h02); mq.push_back(8'h79);
    run_msg(100, 100);
    total++;
    if (got_blk.size() != 1 || got_blk[0][0] !== 32'h87027980) begin
      bad++;
      $display("FAIL reset_mid_fill: n=%0d", got_blk.size());
    end
    fill_rep(8'h61, 56);
    for (int i = 0; i < 56; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'h61; in_last = (i == 55);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    n = 0;
    while (!blk_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    do_reset();
    mq.delete();
    mq.push_back(8'h87); mq.push_back(8'h02); mq.push_back(8'h79);
    run_msg(100, 60);
  endtask

  task automatic test_back_to_back();
    int lens[5] = '{55, 56, 63, 64, 1};
    for (int k = 0; k < 5; k++) begin
      mq.delete();
      for (int i = 0; i < lens[k]; i++) mq.push_back(8'($urandom));
      run_msg(100, 100);
    end
  endtask

  task automatic test_random();
    int len;
    for (int k = 0; k < 25; k++) begin
      len = ($urandom_range(3) == 0) ? $urandom_range(54, 66) : $urandom_range(1, 150);
      mq.delete();
      for (int i = 0; i < len; i++) mq.push_back(8'($urandom));
      run_msg($urandom_range(30, 100), $urandom_range(30, 100));
    end
  endtask

  initial begin
    test_reset();
    test_known();
    test_latency();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
